// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic units.
// Common FSM state type for serial add/sub/compare.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor cell.
// Computes a - b - bin with difference and borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin over WIDTH cycles, LSB first.
// One full-subtractor cell reused with a registered borrow.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-2:0] rd;
   logic [WIDTH-1:0] sh;
   logic             br;
   logic             fs_d;
   logic             fs_b;

   full_subtractor u_fs (
      .a    (ra[0]),
      .b    (rb[0]),
      .bin  (br),
      .d    (fs_d),
      .bout (fs_b)
   );

   // Result register plus the bit produced this cycle.
   assign sh = {fs_d, rd};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         ra    <= '0;
         rb    <= '0;
         rd    <= '0;
         br    <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  br    <= bin;
                  rd    <= '0;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               rd  <= sh[WIDTH-1:1];
               ra  <= ra >> 1;
               rb  <= rb >> 1;
               br  <= fs_b;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  // br here is the borrow into the MSB stage
                  diff  <= sh;
                  bout  <= fs_b;
                  ovf   <= br ^ fs_b;
                  state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule
